io_mmio_responder: RTL and testbench
====================================

# io_mmio_responder

Memory-mapped I/O responder on the CPU data-memory bus: the device end of the load/store accesses the processor issues to addresses 0xFFF0–0xFFFE. Synchronizes and debounces raw board KEY/SW inputs, latches key-press and switch-change events with ready/overrun status, and holds the HEX/LEDR/LEDG display registers. Also provides a prescaled free-running timer and a level interrupt request. Sits beside the data memory array; the CPU's dmemout mux selects `rdata` whenever the address is not in RAM.

## Interface
- DBITS, 16, bus data/address width
- DEBOUNCE_CYCLES, 65535, consecutive stable cycles required before a debounced group updates (≥1)
- TICK_CYCLES, 50000, clock cycles per timer increment (≥1; 1 ms at 50 MHz)

- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  DBITS  byte address from CPU M stage
- wdata  in  DBITS  store data
- we  in  1  store strobe, one cycle per store
- re  in  1  load strobe, one cycle per load (read side effects only)
- rdata  out  DBITS  combinational read data
- key_n  in  4  raw board keys, active-low, asynchronous
- sw  in  10  raw board switches, asynchronous
- hex_out  out  16  seven-segment value
- ledr_out  out  10  red LEDs
- ledg_out  out  8  green LEDs
- irq  out  1  interrupt request, level

## Operation
- Hit = addr[15:4]==12'hFFF; addr[0] ignored. No hit: rdata=16'hDEAD, writes ignored.
- Register map (read value / write effect):
  - FFF0 KDATA: {12'b0, debounced ~key_n} (pressed=1) / ignored. Read with re clears KCTRL.ready.
  - FFF2 SDATA: {6'b0, debounced sw} / ignored. Read with re clears SCTRL.ready.
  - FFF4 KCTRL: {11'b0, ie[4], 2'b0, ovr[1], rdy[0]} / ie←wdata[4]; ovr cleared if wdata[1]=0; rdy not writable.
  - FFF6 SCTRL: same layout for switch events.
  - FFF8 HEX, FFFA LEDR, FFFC LEDG: read back the output register (zero-extended) / load from wdata low bits.
  - FFFE TCNT: timer value / load wdata, prescaler restarts at 0.
- Key event: any debounced key bit 0→1. Switch event: any change in the debounced switch vector. Event sets rdy; event while rdy=1 also sets ovr.
- Debounce per group (keys, switches): raw → two-flop synchronizer → compare against previous synchronized sample; any difference restarts the stability counter; after DEBOUNCE_CYCLES stable cycles the debounced register loads the whole group.
- Timer: prescaler counts 0..TICK_CYCLES-1; on wrap TCNT increments, 16'hFFFF→16'h0000.
- irq = (krdy & kie) | (srdy & sie), from registers only.

## Timing
- Reset: hex_out=0, ledr_out=0, ledg_out=0, irq=0, all rdy/ovr/ie=0, TCNT=0, prescaler=0, synchronizers and debounced keys = released (KDATA=0), switches = 0. Stability counters = 0.
- Input latency: a stable raw change appears in KDATA/SDATA 2 + DEBOUNCE_CYCLES cycles later; rdy/ovr update on the same edge.
- Switches differing from 0 at reset produce one switch event after debounce (by design).
- Writes take effect on the edge where we=1; rdata reflects new value the following cycle.
- Simultaneous: event and clearing read of DATA in same cycle → rdy stays 1, ovr unchanged. Event and ovr-clearing write same cycle → set wins. TCNT write and tick same cycle → write wins.
- we and re both high: treat as write only; no read side effect.
- rst_n assertion mid-debounce discards counters and pending events immediately.

## Structure
- Shared package: register address constants (FFF0…FFFE), KCTRL/SCTRL bit positions, 16'hDEAD no-hit value.
- Sub-module io_debounce #(WIDTH, CYCLES): synchronizer + stability counter + debounced output + one-cycle `changed` pulse; instantiated twice (WIDTH 4 for keys, 10 for switches).

## Test plan
(bench uses DEBOUNCE_CYCLES=4, TICK_CYCLES=3)
- Reset with key_n=4'hF, sw=0 → all outputs 0, rdata at FFF0=16'h0000, irq=0; addr 16'h1234 reads 16'hDEAD.
- key_n=4'b1110 held 10 cycles → KDATA=16'h0001 exactly 6 cycles after change, KCTRL=16'h0001; read FFF0 with re → KCTRL=16'h0000.
- key_n bounces 1110/1111 every 2 cycles for 20 cycles then settles 1111 → KDATA never changes, rdy stays 0.
- Two key presses without reading → KCTRL=16'h0003; write FFF4=16'h0010 → KCTRL=16'h0011, irq=1; read FFF0 → irq=0.
- Store 16'hBEEF to FFF8, 16'h03FF to FFFA, 16'h01A5 to FFFC → hex_out=BEEF, ledr_out=3FF, ledg_out=A5; readbacks 16'hBEEF/16'h03FF/16'h00A5.
- Write FFFE=16'hFFFE → after 3 cycles TCNT=FFFF, after 6 cycles 0000; TCNT write coincident with tick loads written value.

Source files
------------

// File: rtl/io_mmio_responder_pkg.sv
// Shared register map, control-register layout and update helpers for the MMIO responder.
package io_mmio_responder_pkg;

    localparam logic [15:0] ADDR_KDATA = 16'hFFF0;
    localparam logic [15:0] ADDR_SDATA = 16'hFFF2;
    localparam logic [15:0] ADDR_KCTRL = 16'hFFF4;
    localparam logic [15:0] ADDR_SCTRL = 16'hFFF6;
    localparam logic [15:0] ADDR_HEX   = 16'hFFF8;
    localparam logic [15:0] ADDR_LEDR  = 16'hFFFA;
    localparam logic [15:0] ADDR_LEDG  = 16'hFFFC;
    localparam logic [15:0] ADDR_TCNT  = 16'hFFFE;

    localparam logic [15:0] NOHIT_DATA = 16'hDEAD;

    localparam int unsigned RDY_BIT = 0;
    localparam int unsigned OVR_BIT = 1;
    localparam int unsigned IE_BIT  = 4;

    // Register index is the halfword offset inside the 16-byte page.
    typedef enum logic [2:0] {
        REG_KDATA = ADDR_KDATA[3:1],
        REG_SDATA = ADDR_SDATA[3:1],
        REG_KCTRL = ADDR_KCTRL[3:1],
        REG_SCTRL = ADDR_SCTRL[3:1],
        REG_HEX   = ADDR_HEX[3:1],
        REG_LEDR  = ADDR_LEDR[3:1],
        REG_LEDG  = ADDR_LEDG[3:1],
        REG_TCNT  = ADDR_TCNT[3:1]
    } reg_idx_e;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } ctrl_t;

    function automatic logic [15:0] ctrl_word(input ctrl_t c);
        logic [15:0] w;
        w          = '0;
        w[IE_BIT]  = c.ie;
        w[OVR_BIT] = c.ovr;
        w[RDY_BIT] = c.rdy;
        return w;
    endfunction

    // Later assignments win: an event overrides both a clearing read and an ovr-clearing write.
    function automatic ctrl_t ctrl_next(input ctrl_t cur, input logic evt, input logic clr_rd,
                                        input logic wr, input logic [15:0] wd);
        ctrl_t nx;
        nx = cur;
        if (wr) begin
            nx.ie = wd[IE_BIT];
            if (!wd[OVR_BIT]) nx.ovr = 1'b0;
        end
        if (clr_rd) nx.rdy = 1'b0;
        if (evt) begin
            nx.rdy = 1'b1;
            if (cur.rdy && !clr_rd) nx.ovr = 1'b1;
        end
        return nx;
    endfunction

endpackage

// File: rtl/io_mmio_responder_if.sv
// CPU data-bus view of the MMIO responder: CPU is master, responder is slave.
interface io_mmio_responder_if #(
    parameter int unsigned DBITS = 16
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic [DBITS-1:0] rdata;
    logic             we;
    logic             re;

    modport master (output addr, output wdata, output we, output re, input rdata);
    modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus stability counter; the whole group loads once it has held
// steady for CYCLES consecutive synchronized samples.
module io_debounce #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb,
    output logic             changed_c,
    output logic [WIDTH-1:0] next_c
);
    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             load;

    // A fresh sample counts as the first stable cycle; saturate once the threshold is met.
    always_comb begin
        cnt_nx = cnt;
        if (sync2 != prev) begin
            cnt_nx = CW'(1);
        end else if (cnt != CW'(CYCLES)) begin
            cnt_nx = cnt + CW'(1);
        end
        load      = (cnt_nx == CW'(CYCLES));
        changed_c = load && (sync2 != deb);
        next_c    = sync2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            cnt   <= '0;
            deb   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
            cnt   <= cnt_nx;
            if (load) deb <= sync2;
        end
    end

endmodule

// File: rtl/io_mmio_responder.sv
// Device end of the CPU data bus at 0xFFF0-0xFFFE: debounced keys/switches with event
// latching, display registers, prescaled timer and level interrupt.
module io_mmio_responder
    import io_mmio_responder_pkg::*;
#(
    parameter int unsigned DBITS           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 65535,
    parameter int unsigned TICK_CYCLES     = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_mmio_responder_if.slave   bus,
    input  logic [3:0]           key_n,
    input  logic [9:0]           sw,
    output logic [15:0]          hex_out,
    output logic [9:0]           ledr_out,
    output logic [7:0]           ledg_out,
    output logic                 irq
);
    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic             hit;
    reg_idx_e         idx;
    logic             wr_en;
    logic             rd_en;
    logic             unused_addr0;

    logic [3:0]       key_pressed;
    logic [3:0]       key_deb;
    logic [3:0]       key_next;
    logic             key_chg;
    logic [9:0]       sw_deb;
    logic [9:0]       sw_next;
    logic             sw_chg;
    logic             key_evt;
    logic             sw_evt;

    ctrl_t            kctrl;
    ctrl_t            sctrl;
    ctrl_t            kctrl_nx;
    ctrl_t            sctrl_nx;

    logic [PW-1:0]    presc;
    logic [DBITS-1:0] tcnt;
    logic             tick;

    // Address decode; a store on the same cycle as a load suppresses the load side effect.
    assign hit          = (bus.addr[15:4] == ADDR_KDATA[15:4]);
    assign idx          = reg_idx_e'(bus.addr[3:1]);
    assign wr_en        = bus.we & hit;
    assign rd_en        = bus.re & ~bus.we & hit;
    assign unused_addr0 = bus.addr[0];

    assign key_pressed = ~key_n;

    io_debounce #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (key_pressed),
        .deb       (key_deb),
        .changed_c (key_chg),
        .next_c    (key_next)
    );

    io_debounce #(.WIDTH(10), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (sw),
        .deb       (sw_deb),
        .changed_c (sw_chg),
        .next_c    (sw_next)
    );

    // Keys only report presses; switches report any change of the debounced vector.
    assign key_evt = key_chg & (|(key_next & ~key_deb));
    assign sw_evt  = sw_chg & (sw_next != sw_deb);

    always_comb begin
        kctrl_nx = ctrl_next(kctrl, key_evt, rd_en && (idx == REG_KDATA),
                             wr_en && (idx == REG_KCTRL), bus.wdata[15:0]);
        sctrl_nx = ctrl_next(sctrl, sw_evt, rd_en && (idx == REG_SDATA),
                             wr_en && (idx == REG_SCTRL), bus.wdata[15:0]);
    end

    assign tick = (presc == PW'(TICK_CYCLES - 1));

    // Status registers; irq is registered from the same next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kctrl <= '0;
            sctrl <= '0;
            irq   <= 1'b0;
        end else begin
            kctrl <= kctrl_nx;
            sctrl <= sctrl_nx;
            irq   <= (kctrl_nx.rdy & kctrl_nx.ie) | (sctrl_nx.rdy & sctrl_nx.ie);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out  <= '0;
            ledr_out <= '0;
            ledg_out <= '0;
        end else if (wr_en) begin
            case (idx)
                REG_HEX:  hex_out  <= bus.wdata[15:0];
                REG_LEDR: ledr_out <= bus.wdata[9:0];
                REG_LEDG: ledg_out <= bus.wdata[7:0];
                default:  ;
            endcase
        end
    end

    // A TCNT store beats a coincident tick and restarts the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tcnt  <= '0;
        end else if (wr_en && (idx == REG_TCNT)) begin
            presc <= '0;
            tcnt  <= bus.wdata;
        end else if (tick) begin
            presc <= '0;
            tcnt  <= tcnt + DBITS'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        bus.rdata = DBITS'(NOHIT_DATA);
        if (hit) begin
            case (idx)
                REG_KDATA: bus.rdata = DBITS'(key_deb);
                REG_SDATA: bus.rdata = DBITS'(sw_deb);
                REG_KCTRL: bus.rdata = DBITS'(ctrl_word(kctrl));
                REG_SCTRL: bus.rdata = DBITS'(ctrl_word(sctrl));
                REG_HEX:   bus.rdata = DBITS'(hex_out);
                REG_LEDR:  bus.rdata = DBITS'(ledr_out);
                REG_LEDG:  bus.rdata = DBITS'(ledg_out);
                REG_TCNT:  bus.rdata = tcnt;
                default:   bus.rdata = DBITS'(NOHIT_DATA);
            endcase
        end
    end

endmodule

// File: tb/tb_io_mmio_responder.sv
// Bench for io_mmio_responder: lockstep reference model plus directed vectors and random traffic.
module tb_io_mmio_responder;
    localparam int unsigned D    = 4;
    localparam int unsigned T    = 3;
    localparam int          MAXE = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;
    logic        irq;

    always #5 clk = ~clk;

    io_mmio_responder_if #(.DBITS(16)) bus ();

    io_mmio_responder #(.DBITS(16), .DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .key_n    (key_n),
        .sw       (sw),
        .hex_out  (hex_out),
        .ledr_out (ledr_out),
        .ledg_out (ledg_out),
        .irq      (irq)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: raw input history per edge, debounced value = a window of D equal samples.
    logic [3:0]  kh [0:MAXE];
    logic [9:0]  sh [0:MAXE];
    int          e;
    logic [3:0]  m_kdeb;
    logic [9:0]  m_sdeb;
    logic [2:0]  m_kc;
    logic [2:0]  m_sc;
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [15:0] t_val;
    int          t_edge;

    function automatic logic [3:0] kraw(input int i);
        return (i < 1) ? 4'h0 : kh[i];
    endfunction

    function automatic logic [9:0] sraw(input int i);
        return (i < 1) ? 10'h0 : sh[i];
    endfunction

    function automatic logic [15:0] m_tcnt();
        return 16'(32'(t_val) + (e - t_edge) / T);
    endfunction

    // Control word {ie, ovr, rdy} as a formula of the event, clearing read and control write.
    function automatic logic [2:0] upd(input logic [2:0] c, input logic evt, input logic rclr,
                                       input logic wc, input logic [15:0] wd);
        logic ie, ovr, rdy;
        ie  = wc ? wd[4] : c[2];
        rdy = evt | (c[0] & ~rclr);
        ovr = (evt & c[0] & ~rclr) | (c[1] & ~(wc & ~wd[1]));
        return {ie, ovr, rdy};
    endfunction

    function automatic logic [15:0] m_rdata(input logic [15:0] a);
        logic [2:0] ix;
        if (a[15:4] != 12'hFFF) return 16'hDEAD;
        ix = a[3:1];
        case (ix)
            3'd0: return {12'h0, m_kdeb};
            3'd1: return {6'h0, m_sdeb};
            3'd2: return {11'h0, m_kc[2], 2'b00, m_kc[1], m_kc[0]};
            3'd3: return {11'h0, m_sc[2], 2'b00, m_sc[1], m_sc[0]};
            3'd4: return m_hex;
            3'd5: return {6'h0, m_ledr};
            3'd6: return {8'h0, m_ledg};
            default: return m_tcnt();
        endcase
    endfunction

    function automatic logic m_irq();
        return (m_kc[0] & m_kc[2]) | (m_sc[0] & m_sc[2]);
    endfunction

    task automatic model_reset();
        e = 0; m_kdeb = '0; m_sdeb = '0; m_kc = '0; m_sc = '0;
        m_hex = '0; m_ledr = '0; m_ledg = '0; t_val = '0; t_edge = 0;
    endtask

    task automatic model_edge(input logic [3:0] kn, input logic [9:0] s, input logic [15:0] a,
                              input logic [15:0] wd, input logic w, input logic r);
        logic [3:0] nk;
        logic [9:0] ns;
        logic       kok, sok, kev, sev, hit, wr, rd;
        logic [2:0] ix;
        e++;
        kh[e] = ~kn;
        sh[e] = s;
        kok = 1'b1; sok = 1'b1;
        for (int i = e - 1 - int'(D); i < e - 2; i++) begin
            if (kraw(i) != kraw(e - 2)) kok = 1'b0;
            if (sraw(i) != sraw(e - 2)) sok = 1'b0;
        end
        nk  = kok ? kraw(e - 2) : m_kdeb;
        ns  = sok ? sraw(e - 2) : m_sdeb;
        kev = |(nk & ~m_kdeb);
        sev = (ns != m_sdeb);
        hit = (a[15:4] == 12'hFFF);
        ix  = a[3:1];
        wr  = w & hit;
        rd  = r & ~w & hit;
        m_kc = upd(m_kc, kev, rd && ix == 3'd0, wr && ix == 3'd2, wd);
        m_sc = upd(m_sc, sev, rd && ix == 3'd1, wr && ix == 3'd3, wd);
        if (wr && ix == 3'd4) m_hex  = wd;
        if (wr && ix == 3'd5) m_ledr = wd[9:0];
        if (wr && ix == 3'd6) m_ledg = wd[7:0];
        if (wr && ix == 3'd7) begin t_val = wd; t_edge = e; end
        m_kdeb = nk;
        m_sdeb = ns;
    endtask

    // One clock cycle, entered and left at a falling edge; checks the pre-edge state.
    task automatic step(input logic [3:0] kn, input logic [9:0] s, input logic [15:0] a,
                        input logic [15:0] wd, input logic w, input logic r,
                        output logic [15:0] rd_seen);
        key_n = kn; sw = s;
        bus.addr = a; bus.wdata = wd; bus.we = w; bus.re = r;
        #1;
        rd_seen = bus.rdata;
        chk($sformatf("rdata@%h", a), bus.rdata, m_rdata(a));
        chk("hex_out", hex_out, m_hex);
        chk("ledr_out", {6'h0, ledr_out}, {6'h0, m_ledr});
        chk("ledg_out", {8'h0, ledg_out}, {8'h0, m_ledg});
        chk("irq", {15'h0, irq}, {15'h0, m_irq()});
        model_edge(kn, s, a, wd, w, r);
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] wd;
        logic        w;
        logic        cmp;
        logic [15:0] exp;
    } vec_t;

    vec_t        vt [10];
    logic [15:0] rd;
    logic [3:0]  rk;
    logic [9:0]  rs;

    initial begin
        rst_n = 1'b0; key_n = 4'hF; sw = '0;
        bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("reset_hex", hex_out, 16'h0);
        chk("reset_irq", {15'h0, irq}, 16'h0);
        step(4'hF, '0, 16'hFFF0, 16'h0, 1'b0, 1'b0, rd);
        chk("reset_kdata", rd, 16'h0000);
        step(4'hF, '0, 16'h1234, 16'h0, 1'b0, 1'b0, rd);
        chk("nohit_read", rd, 16'hDEAD);
        repeat (8) step(4'hF, '0, 16'hFFF4, 16'h0, 1'b0, 1'b0, rd);

        // Single press: data appears exactly 2+D cycles after the raw change.
        for (int k = 0; k < 10; k++) begin
            step(4'b1110, '0, 16'hFFF0, 16'h0, 1'b0, 1'b0, rd);
            chk($sformatf("press_kdata_%0d", k), rd, (k < 6) ? 16'h0000 : 16'h0001);
        end
        step(4'b1110, '0, 16'hFFF4, 16'h0, 1'b0, 1'b0, rd);
        chk("press_kctrl", rd, 16'h0001);
        step(4'b1110, '0, 16'hFFF0, 16'h0, 1'b0, 1'b1, rd);
        step(4'b1110, '0, 16'hFFF4, 16'h0, 1'b0, 1'b0, rd);
        chk("read_clears_rdy", rd, 16'h0000);
        repeat (10) step(4'hF, '0, 16'hFFF4, 16'h0, 1'b0, 1'b0, rd);
        chk("release_no_event", rd, 16'h0000);

        // Bouncing key never stays stable long enough.
        for (int k = 0; k < 20; k++) begin
            step(((k / 2) % 2) != 0 ? 4'hF : 4'hE, '0, 16'hFFF0, 16'h0, 1'b0, 1'b0, rd);
            chk("bounce_kdata", rd, 16'h0000);
        end
        repeat (10) step(4'hF, '0, 16'hFFF0, 16'h0, 1'b0, 1'b0, rd);
        step(4'hF, '0, 16'hFFF4, 16'h0, 1'b0, 1'b0, rd);
        chk("bounce_kctrl", rd, 16'h0000);

        // Two presses without a read: overrun, then interrupt enable and clear.
        for (int p = 0; p < 2; p++) begin
            repeat (8) step(4'b1101, '0, 16'hFFF2, 16'h0, 1'b0, 1'b0, rd);
            repeat (8) step(4'hF, '0, 16'hFFF2, 16'h0, 1'b0, 1'b0, rd);
        end
        step(4'hF, '0, 16'hFFF4, 16'h0, 1'b0, 1'b0, rd);
        chk("overrun_kctrl", rd, 16'h0003);
        step(4'hF, '0, 16'hFFF4, 16'h0010, 1'b1, 1'b0, rd);
        step(4'hF, '0, 16'hFFF4, 16'h0, 1'b0, 1'b0, rd);
        chk("ie_kctrl", rd, 16'h0011);
        chk("irq_set", {15'h0, irq}, 16'h0001);
        step(4'hF, '0, 16'hFFF0, 16'h0, 1'b0, 1'b1, rd);
        step(4'hF, '0, 16'hFFF4, 16'h0, 1'b0, 1'b0, rd);
        chk("irq_cleared", {15'h0, irq}, 16'h0000);

        // Display registers, no-hit writes and the ignored address bit 0.
        vt[0] = '{16'hFFF8, 16'hBEEF, 1'b1, 1'b0, 16'h0};
        vt[1] = '{16'hFFFA, 16'h03FF, 1'b1, 1'b0, 16'h0};
        vt[2] = '{16'hFFFC, 16'h01A5, 1'b1, 1'b0, 16'h0};
        vt[3] = '{16'hFFF8, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
        vt[4] = '{16'hFFFA, 16'h0000, 1'b0, 1'b1, 16'h03FF};
        vt[5] = '{16'hFFFC, 16'h0000, 1'b0, 1'b1, 16'h00A5};
        vt[6] = '{16'h1238, 16'h5555, 1'b1, 1'b1, 16'hDEAD};
        vt[7] = '{16'hFFF9, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
        vt[8] = '{16'hFFFB, 16'h0000, 1'b0, 1'b1, 16'h03FF};
        vt[9] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'hDEAD};
        for (int i = 0; i < 10; i++) begin
            step(4'hF, '0, vt[i].a, vt[i].wd, vt[i].w, 1'b0, rd);
            if (vt[i].cmp) chk($sformatf("vec_%0d", i), rd, vt[i].exp);
        end
        chk("hex_beef", hex_out, 16'hBEEF);
        chk("ledr_3ff", {6'h0, ledr_out}, 16'h03FF);
        chk("ledg_a5", {8'h0, ledg_out}, 16'h00A5);

        // Timer wrap, then a store landing on a tick edge.
        step(4'hF, '0, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, rd);
        for (int j = 1; j <= 13; j++) begin
            step(4'hF, '0, 16'hFFFE, 16'h1234, (j == 9) ? 1'b1 : 1'b0, 1'b0, rd);
            if (j <= 7)
                chk($sformatf("tcnt_%0d", j), rd, (j < 4) ? 16'hFFFE : (j < 7) ? 16'hFFFF : 16'h0000);
            else if (j >= 10)
                chk($sformatf("tcnt_%0d", j), rd, (j < 13) ? 16'h1234 : 16'h1235);
        end

        // Random traffic against the model.
        rk = 4'hF; rs = '0;
        for (int n = 0; n < 1500; n++) begin
            int          op;
            logic [15:0] a, wd;
            logic        w, r;
            if ($urandom_range(0, 5) == 0) rk = 4'($urandom);
            if ($urandom_range(0, 7) == 0) rs = 10'($urandom);
            op = $urandom_range(0, 9);
            a  = {12'hFFF, 4'($urandom)};
            wd = 16'($urandom);
            w  = 1'b0; r = 1'b0;
            case (op)
                0, 1, 2, 3: r = 1'b1;
                4, 5, 6:    w = 1'b1;
                8: begin a = 16'($urandom); w = 1'($urandom); r = 1'($urandom); end
                9: begin w = 1'b1; r = 1'b1; end
                default: ;
            endcase
            step(rk, rs, a, wd, w, r, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
